bird_motion_ctrl: RTL and testbench
===================================

BIRD_MOTION_CTRL -- requirements
Module: bird_motion_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 4: clk cycles per motion tick, ≥2.
REQ-002 Parameter RISE_STEPS, default 3: incr steps issued per flap, ≥1.
REQ-003 Parameter FALL_DIV, default 2: motion ticks per gravity decr step, ≥1.
REQ-004 clk  input  1  clock; all state on posedge clk.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  game running; 0 = bird frozen.
REQ-007 flap  input  1  player button, level, already synchronous to clk.
REQ-008 height  input  4  current bird height from the height counter, feedback only.
REQ-009 incr  output  1  one-cycle registered pulse: raise height by 1.
REQ-010 decr  output  1  one-cycle registered pulse: lower height by 1.

Function
REQ-011 SHALL implement FSM states IDLE, RISE, FALL.
REQ-012 SHALL detect a press as flap=1 while the registered previous flap=0; a held flap SHALL yield exactly one press.
REQ-013 Tick counter SHALL count 0..TICK_DIV-1 while enable=1, wrapping to 0; tick = (count==TICK_DIV-1); held at 0 while enable=0; a press SHALL NOT restart it.
REQ-014 IDLE: no pulses; enable=1 SHALL move to FALL next cycle with fall counter 0.
REQ-015 FALL: each tick increments the fall counter; when it reaches FALL_DIV-1 on a tick, it SHALL wrap to 0 and decr SHALL assert the following cycle, unless height==0.
REQ-016 Press in FALL or RISE SHALL move to RISE with rise counter = RISE_STEPS; in RISE a press SHALL restart the counter.
REQ-017 RISE: each tick SHALL assert incr the following cycle unless height==15, and decrement the rise counter; on reaching 0, SHALL move to FALL with fall counter 0.
REQ-018 Press and tick in the same cycle: the press SHALL win; no pulse is generated for that tick.
REQ-019 Saturation-suppressed steps SHALL still consume their tick and rise count.
REQ-020 incr and decr SHALL never be 1 in the same cycle.
REQ-021 Latency: pulse is asserted exactly 1 cycle after its tick and lasts exactly 1 cycle.
REQ-022 enable=0 in any state SHALL force IDLE next cycle, clear all counters and deassert incr/decr next cycle.

Reset
REQ-023 reset SHALL override all inputs, including enable and flap.
REQ-024 On reset, the next state SHALL be IDLE, incr=0, decr=0, all counters 0, and the previous-flap register 0.
REQ-025 Reset mid-RISE or mid-FALL SHALL drop any pending pulse.

Structure
REQ-026 Package bird_pkg SHALL hold the state enum, HEIGHT_W=4, HEIGHT_MIN=0 and HEIGHT_MAX=15.
REQ-027 The tick divider SHALL be a sub-module tick_gen (parameter DIV; ports clk, reset, en, tick).
REQ-028 Output ports incr/decr SHALL connect directly to the height counter incr/decr inputs.

Verification (default parameters)
REQ-029 Reset 2 cycles, enable=1, height=8, no flap, 16 cycles -> exactly 2 one-cycle decr pulses, 8 cycles apart; incr stays 0.
REQ-030 In FALL, flap held high 20 cycles, height=8 -> exactly 3 incr pulses 4 cycles apart, then decr pulses resume every 8 cycles.
REQ-031 height=15, single press -> 0 incr pulses; RISE lasts 3 ticks, then FALL.
REQ-032 height=0 in FALL for 24 cycles -> 0 decr pulses.
REQ-033 Second press one cycle after the first incr -> 4 incr total; press coincident with a tick -> that tick yields no pulse.
REQ-034 enable=0 or reset asserted mid-RISE -> incr/decr=0 from the next cycle; state IDLE; re-enable -> FALL with a fresh tick count.

Source files
------------

// File: rtl/bird_pkg.sv
// Shared types and height limits for the bird motion controller.
package bird_pkg;

    localparam int unsigned HEIGHT_W = 4;
    localparam logic [HEIGHT_W-1:0] HEIGHT_MIN = 4'd0;
    localparam logic [HEIGHT_W-1:0] HEIGHT_MAX = 4'd15;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRise = 2'd1,
        StFall = 2'd2
    } state_t;

endpackage

// File: rtl/bird_motion_ctrl_if.sv
// Player/height-counter side signals of the bird motion controller.
interface bird_motion_ctrl_if;
    import bird_pkg::*;

    logic                enable;
    logic                flap;
    logic [HEIGHT_W-1:0] height;
    logic                incr;
    logic                decr;

    modport master (
        output enable,
        output flap,
        output height,
        input  incr,
        input  decr
    );

    modport slave (
        input  enable,
        input  flap,
        input  height,
        output incr,
        output decr
    );

endinterface

// File: rtl/tick_gen.sv
// Free-running motion tick divider; held at zero while disabled.
module tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;
    logic          at_top;

    assign at_top = (count == CW'(DIV - 1));
    assign tick   = en && at_top;

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            count <= '0;
        end else if (at_top) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/bird_motion_ctrl.sv
// Flap/gravity FSM turning button presses and motion ticks into height incr/decr pulses.
module bird_motion_ctrl
    import bird_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 4,
    parameter int unsigned RISE_STEPS = 3,
    parameter int unsigned FALL_DIV   = 2
) (
    input logic             clk,
    input logic             reset,
    bird_motion_ctrl_if.slave bus
);

    localparam int unsigned RW = $clog2(RISE_STEPS + 1);
    localparam int unsigned FW = (FALL_DIV > 1) ? $clog2(FALL_DIV) : 1;

    state_t        state_q, state_d;
    logic [RW-1:0] rise_q, rise_d;
    logic [FW-1:0] fall_q, fall_d;
    logic          incr_q, incr_d;
    logic          decr_q, decr_d;
    logic          flap_q;
    logic          press;
    logic          tick;

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (bus.enable),
        .tick  (tick)
    );

    assign press    = bus.flap && !flap_q;
    assign bus.incr = incr_q;
    assign bus.decr = decr_q;

    always_comb begin
        state_d = state_q;
        rise_d  = rise_q;
        fall_d  = fall_q;
        incr_d  = 1'b0;
        decr_d  = 1'b0;
        if (!bus.enable) begin
            state_d = StIdle;
            rise_d  = '0;
            fall_d  = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StFall;
                    rise_d  = '0;
                    fall_d  = '0;
                end
                StFall: begin
                    // A press outranks a coinciding tick, which then produces no step.
                    if (press) begin
                        state_d = StRise;
                        rise_d  = RW'(RISE_STEPS);
                    end else if (tick) begin
                        if (fall_q == FW'(FALL_DIV - 1)) begin
                            fall_d = '0;
                            decr_d = (bus.height != HEIGHT_MIN);
                        end else begin
                            fall_d = fall_q + FW'(1);
                        end
                    end
                end
                StRise: begin
                    if (press) begin
                        rise_d = RW'(RISE_STEPS);
                    end else if (tick) begin
                        // Saturated steps still use up their rise count.
                        incr_d = (bus.height != HEIGHT_MAX);
                        rise_d = rise_q - RW'(1);
                        if (rise_q == RW'(1)) begin
                            state_d = StFall;
                            rise_d  = '0;
                            fall_d  = '0;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    rise_d  = '0;
                    fall_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            rise_q  <= '0;
            fall_q  <= '0;
            incr_q  <= 1'b0;
            decr_q  <= 1'b0;
            flap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            incr_q  <= incr_d;
            decr_q  <= decr_d;
            flap_q  <= bus.flap;
        end
    end

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Scoreboard bench for bird_motion_ctrl: behavioural model feeds expected pulses and windows.
module tb_bird_motion_ctrl;

    localparam int TD = 4;
    localparam int RS = 3;
    localparam int FD = 2;

    typedef struct {
        int cyc;
        bit inc;
        bit dec;
    } exp_t;

    typedef struct {
        string name;
        int    s;
        int    e;
        int    inc;
        int    dec;
    } win_t;

    logic clk;
    logic reset;

    bird_motion_ctrl_if bus ();

    bird_motion_ctrl #(
        .TICK_DIV   (TD),
        .RISE_STEPS (RS),
        .FALL_DIV   (FD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t exp_q[$];
    win_t win_q[$];
    bit   inc_hist[int];
    bit   dec_hist[int];
    int   edge_id = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done = 0;
    int   w_start = 0;

    // Behavioural model state: mode 0 = idle, 1 = falling, 2 = rising.
    int m_mode = 0;
    int m_tick = 0;
    int m_fall = 0;
    int m_rise = 0;
    bit m_prev = 0;
    int last_incr_edge = -1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model(input bit r, input bit en, input bit f, input int h);
        bit press;
        bit tick;
        bit inc;
        bit dec;
        inc = 0;
        dec = 0;
        if (r) begin
            m_mode = 0;
            m_tick = 0;
            m_fall = 0;
            m_rise = 0;
            m_prev = 0;
            return;
        end
        press  = f && !m_prev;
        m_prev = f;
        tick   = en && (m_tick == TD - 1);
        m_tick = en ? (m_tick + 1) % TD : 0;
        if (!en) begin
            m_mode = 0;
            m_fall = 0;
            m_rise = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
            m_fall = 0;
        end else if (press) begin
            m_mode = 2;
            m_rise = RS;
        end else if (tick && m_mode == 1) begin
            m_fall++;
            if (m_fall == FD) begin
                m_fall = 0;
                dec = (h > 0);
            end
        end else if (tick && m_mode == 2) begin
            m_rise--;
            inc = (h < 15);
            if (m_rise == 0) begin
                m_mode = 1;
                m_fall = 0;
            end
        end
        if (inc || dec) exp_q.push_back('{cyc: edge_id, inc: inc, dec: dec});
        if (inc) last_incr_edge = edge_id;
    endtask

    task automatic step(input bit r, input bit en, input bit f, input int h);
        reset      = r;
        bus.enable = en;
        bus.flap   = f;
        bus.height = 4'(h);
        @(posedge clk);
        edge_id++;
        model(r, en, f, h);
        #1;
    endtask

    task automatic steps(input int n, input bit en, input bit f, input int h);
        for (int i = 0; i < n; i++) step(1'b0, en, f, h);
    endtask

    task automatic win_open();
        w_start = edge_id + 1;
    endtask

    task automatic win_close(input string name, input int inc, input int dec);
        win_q.push_back('{name: name, s: w_start, e: edge_id, inc: inc, dec: dec});
    endtask

    // Monitor: pops expected pulses and closes count windows.
    initial begin
        forever begin
            @(negedge clk);
            if (edge_id > 0) begin
                inc_hist[edge_id] = bus.incr;
                dec_hist[edge_id] = bus.decr;
                checks++;
                if (bus.incr && bus.decr) begin
                    errors++;
                    $display("FAIL exclusive edge=%0d incr=%0b decr=%0b required not both 1",
                             edge_id, bus.incr, bus.decr);
                end
                if (bus.incr || bus.decr) begin
                    checks++;
                    if (exp_q.size() == 0 || exp_q[0].cyc != edge_id) begin
                        errors++;
                        $display("FAIL unexpected_pulse edge=%0d incr=%0b decr=%0b required none",
                                 edge_id, bus.incr, bus.decr);
                    end else begin
                        if (exp_q[0].inc != bus.incr || exp_q[0].dec != bus.decr) begin
                            errors++;
                            $display("FAIL pulse_kind edge=%0d got incr=%0b decr=%0b required incr=%0b decr=%0b",
                                     edge_id, bus.incr, bus.decr, exp_q[0].inc, exp_q[0].dec);
                        end
                        void'(exp_q.pop_front());
                    end
                end else if (exp_q.size() > 0 && exp_q[0].cyc <= edge_id) begin
                    checks++;
                    errors++;
                    $display("FAIL missed_pulse edge=%0d got none required incr=%0b decr=%0b",
                             exp_q[0].cyc, exp_q[0].inc, exp_q[0].dec);
                    void'(exp_q.pop_front());
                end
                while (win_q.size() > 0 && win_q[0].e <= edge_id) begin
                    win_t w;
                    int   ni;
                    int   nd;
                    w  = win_q.pop_front();
                    ni = 0;
                    nd = 0;
                    for (int c = w.s; c <= w.e; c++) begin
                        if (inc_hist.exists(c) && inc_hist[c]) ni++;
                        if (dec_hist.exists(c) && dec_hist[c]) nd++;
                    end
                    if (w.inc >= 0) begin
                        checks++;
                        if (ni != w.inc) begin
                            errors++;
                            $display("FAIL %s incr_count got %0d required %0d", w.name, ni, w.inc);
                        end
                    end
                    if (w.dec >= 0) begin
                        checks++;
                        if (nd != w.dec) begin
                            errors++;
                            $display("FAIL %s decr_count got %0d required %0d", w.name, nd, w.dec);
                        end
                    end
                end
            end
            if (done) begin
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL leftover_expected got %0d pending required 0", exp_q.size());
                end
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit f;
        int h;
        reset      = 1'b1;
        bus.enable = 1'b1;
        bus.flap   = 1'b1;
        bus.height = 4'd8;

        win_open();
        step(1'b1, 1'b1, 1'b1, 8);
        step(1'b1, 1'b1, 1'b1, 8);
        win_close("reset_quiet", 0, 0);

        win_open();
        steps(17, 1'b1, 1'b0, 8);
        win_close("fall_decr", 0, 2);

        win_open();
        steps(24, 1'b1, 1'b0, 0);
        win_close("floor_hold", 0, 0);

        win_open();
        step(1'b0, 1'b1, 1'b1, 15);
        steps(12, 1'b1, 1'b0, 15);
        win_close("ceiling_press", 0, -1);

        win_open();
        steps(20, 1'b1, 1'b1, 8);
        win_close("held_flap_rise", 3, -1);
        steps(14, 1'b1, 1'b0, 8);

        // Second press right after the first incr restarts the rise.
        win_open();
        step(1'b0, 1'b1, 1'b1, 8);
        for (int i = 0; i < 12 && last_incr_edge != edge_id; i++) step(1'b0, 1'b1, 1'b0, 8);
        step(1'b0, 1'b1, 1'b1, 8);
        steps(16, 1'b1, 1'b0, 8);
        win_close("repress_rise", 4, -1);

        step(1'b0, 1'b1, 1'b1, 8);
        step(1'b0, 1'b1, 1'b0, 8);
        for (int i = 0; i < TD && m_tick != TD - 1; i++) step(1'b0, 1'b1, 1'b0, 8);
        win_open();
        step(1'b0, 1'b1, 1'b1, 8);
        win_close("press_on_tick", 0, 0);
        steps(14, 1'b1, 1'b0, 8);

        step(1'b0, 1'b1, 1'b1, 8);
        for (int i = 0; i < 10 && last_incr_edge != edge_id; i++) step(1'b0, 1'b1, 1'b0, 8);
        win_open();
        steps(3, 1'b0, 1'b0, 8);
        win_close("disable_quiet", 0, 0);
        win_open();
        steps(9, 1'b1, 1'b0, 8);
        win_close("reenable_fall", 0, 1);

        step(1'b0, 1'b1, 1'b1, 8);
        for (int i = 0; i < TD && m_tick != TD - 1; i++) step(1'b0, 1'b1, 1'b0, 8);
        win_open();
        step(1'b1, 1'b1, 1'b0, 8);
        step(1'b1, 1'b1, 1'b0, 8);
        win_close("reset_mid_rise", 0, 0);
        win_open();
        steps(9, 1'b1, 1'b0, 8);
        win_close("after_reset_fall", 0, 1);

        f = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            int sel;
            if ($urandom_range(0, 9) < 2) f = ~f;
            sel = $urandom_range(0, 9);
            h = (sel == 0) ? 0 : (sel == 1) ? 15 : $urandom_range(0, 15);
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) >= 3), f, h);
        end
        steps(3, 1'b0, 1'b0, 8);
        done = 1'b1;
    end

endmodule
